// File: rtl/alu_mul_seq.sv
// Multi-cycle 16x16 (truncated to 16 bits) multiply sequencer that drives the shared ALU.
// Optional build macro MUL_EARLY_EXIT_EN: finish once the remaining multiplier bits are zero.
module alu_mul_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] mul_a,
  input  logic [15:0] mul_b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic [15:0] alu_op1,
  output logic [15:0] alu_op2,
  output logic [2:0]  alu_operation,
  input  logic [15:0] alu_result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SHL,
    S_SHR,
    S_DONE
  } state_t;

  localparam logic [2:0] OP_ADD   = 3'b100;
  localparam logic [2:0] OP_SHIFT = 3'b000;
  localparam logic [2:0] OP_DFLT  = 3'b011;

  state_t      state;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic [15:0] acc;
  logic [3:0]  iter;
  logic        last_iter;

`ifdef MUL_EARLY_EXIT_EN
  assign last_iter = (iter == 4'd15) || (alu_result == '0);
`else
  assign last_iter = (iter == 4'd15);
`endif

  // ALU inputs are a pure decode of state and registers, so they are stable
  // for the whole cycle and the result is consumed at the edge ending the state.
  always_comb begin
    alu_op1       = '0;
    alu_op2       = '0;
    alu_operation = OP_DFLT;
    case (state)
      S_ADD: begin
        alu_op1       = acc;
        alu_op2       = mcand;
        alu_operation = OP_ADD;
      end
      S_SHL: begin
        alu_op1       = mcand;
        alu_op2       = 16'h0001;
        alu_operation = OP_SHIFT;
      end
      S_SHR: begin
        alu_op1       = mplier;
        alu_op2       = 16'hFFFF;
        alu_operation = OP_SHIFT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      iter    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand  <= mul_a;
            mplier <= mul_b;
            acc    <= '0;
            iter   <= '0;
            busy   <= 1'b1;
`ifdef MUL_EARLY_EXIT_EN
            if (mul_b == '0) begin
              state   <= S_DONE;
              done    <= 1'b1;
              product <= '0;
            end else begin
              state <= S_ADD;
            end
`else
            state <= S_ADD;
`endif
          end
        end
        S_ADD: begin
          if (mplier[0]) acc <= alu_result;
          state <= S_SHL;
        end
        S_SHL: begin
          mcand <= alu_result;
          state <= S_SHR;
        end
        S_SHR: begin
          mplier <= alu_result;
          if (last_iter) begin
            state   <= S_DONE;
            done    <= 1'b1;
            product <= acc;
          end else begin
            iter  <= iter + 4'd1;
            state <= S_ADD;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq with a behavioural model of the shared combinational ALU.
// Define MUL_EARLY_EXIT_EN for both RTL and bench to test the early-exit build.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] mul_a = '0;
  logic [15:0] mul_b = '0;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic [15:0] alu_op1;
  logic [15:0] alu_op2;
  logic [2:0]  alu_operation;
  logic [15:0] alu_result;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  alu_mul_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mul_a(mul_a), .mul_b(mul_b),
    .busy(busy), .done(done), .product(product),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_operation(alu_operation),
    .alu_result(alu_result)
  );

  // ALU model: 100 add, 000 shift by signed op2 (negative = right), others 0.
  always_comb begin
    alu_result = '0;
    if (alu_operation == 3'b100)
      alu_result = alu_op1 + alu_op2;
    else if (alu_operation == 3'b000) begin
      if (alu_op2[15]) alu_result = alu_op1 >> (16'h0 - alu_op2);
      else             alu_result = alu_op1 << alu_op2;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edge index (after E0) at which DONE is entered.
  function automatic int exp_latency(input logic [15:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int k;
    k = 0;
    for (int i = 0; i < 16; i++) if (b[i]) k = i + 1;
    return 3 * k;
`else
    return 48;
`endif
  endfunction

  // Runs one multiply. inject: pulse a second start sampled at E10.
  // abort_at > 0: assert reset after that edge and expect no result.
  task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input bit chk_ops, input bit inject, input int abort_at);
    int n;
    int dones;
    logic [15:0] exp_p;
    @(negedge clk);
    mul_a = a; mul_b = b; start = 1'b1;
    exp_q.push_back(a * b);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_rise"}, busy, 1'b1);
    n = 0;
    forever begin
      if (inject && n == 9) begin start = 1'b1; mul_a = 16'd7; mul_b = 16'd7; end
      if (inject && n == 10) start = 1'b0;
      if (abort_at > 0 && n == abort_at) break;
      if (done || n >= 60) break;
      if (chk_ops && n < 6)
        check({tag, "_aluop"}, alu_operation, (n % 3 == 0) ? 3'b100 : 3'b000);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    if (abort_at > 0) begin
      rst_n = 1'b0;
      #1;
      check({tag, "_rst_busy"}, busy, 1'b0);
      check({tag, "_rst_done"}, done, 1'b0);
      check({tag, "_rst_product"}, product, 16'h0);
      check({tag, "_rst_aluop"}, alu_operation, 3'b011);
      void'(exp_q.pop_front());
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 60; i++) begin
        @(posedge clk); #1;
        if (done) dones++;
      end
      check({tag, "_no_done_after_abort"}, dones, 0);
      return;
    end
    check({tag, "_latency"}, n, exp_latency(b));
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 1, 0);
    end else begin
      exp_p = exp_q.pop_front();
      check({tag, "_product"}, product, exp_p);
    end
    @(posedge clk); #1;
    check({tag, "_done_fall"}, done, 1'b0);
    check({tag, "_busy_fall"}, busy, 1'b0);
    if (inject) begin
      dones = 0;
      for (int i = 0; i < 60; i++) begin
        @(posedge clk); #1;
        if (done) dones++;
      end
      check({tag, "_no_extra_done"}, dones, 0);
      check({tag, "_product_held"}, product, 16'd15);
    end
  endtask

  initial begin
    #12;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_product", product, 16'h0);
    check("reset_aluop", alu_operation, 3'b011);
    check("reset_op1", alu_op1, 16'h0);
    check("reset_op2", alu_op2, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_mul("m3x5", 16'd3, 16'd5, 1'b0, 1'b0, 0);
    run_mul("mffff", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 0);
    run_mul("m0100", 16'h0100, 16'h0100, 1'b1, 1'b0, 0);
    run_mul("mzero", 16'h1234, 16'h0000, 1'b0, 1'b0, 0);
    run_mul("ignore", 16'd3, 16'd5, 1'b0, 1'b1, 0);
    run_mul("abort", 16'd3, 16'd5, 1'b0, 1'b0, 20);
    check("abort_product_cleared", product, 16'h0);
    run_mul("m2x9", 16'd2, 16'd9, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++)
      run_mul("rand", 16'($urandom), 16'($urandom), 1'b0, 1'b0, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
